mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised, iterative, shared multiply/divide engine for the EX stage. It replaces the combinational multiplier, the two-pass MADD/MSUB counter scheme and the separate divider handshake.
- Handles signed/unsigned MULT, DIV, MADD and MSUB with one radix-2 step per cycle.
- The EX stage holds its stall request while busy_o is high. It takes result_o, formatted as {HI,LO}, when ready_o pulses.

Parameters:
- WIDTH, 32, operand width. Must be an even value ≥ 4; results are 2*WIDTH bits wide.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter. Local parameter, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE.
- annul_i  in  1  abort the operation in flight (flush/exception).
- op_i  in  3  operation code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADDU, 101 MADD, 110 MSUBU, 111 MSUB.
- opdata1_i  in  WIDTH  multiplicand or dividend.
- opdata2_i  in  WIDTH  multiplier or divisor.
- hilo_i  in  2*WIDTH  accumulator {HI,LO} for MADD/MSUB, already forwarded.
- busy_o  out  1  operation in progress.
- ready_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  2*WIDTH  MUL/MADD/MSUB: {hi,lo}. DIV: {remainder,quotient}.
- div_by_zero_o  out  1  the last completed DIV/DIVU had divisor 0.

Behaviour:
- Reset (rst=0, at any time, including mid-operation): state=IDLE; busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0, counter=0.
- State machine: IDLE -> CALC -> FIN -> IDLE. All outputs are registered.
- IDLE:
  - On the edge sampling start_i=1 and annul_i=0, latch op_i, hilo_i, the operand magnitudes (two's-complement negated if op_i[0]=1 and MSB=1) and the result sign flags. Set busy_o=1, counter=0, go to CALC.
  - start_i with annul_i=1 is ignored.
- Divisor zero (DIV/DIVU, opdata2_i=0), special case:
  - Go directly to FIN; no iterations are performed.
  - At the FIN edge: result_o=0, div_by_zero_o=1, ready_o=1.
- CALC: one step per edge; the counter increments; after WIDTH steps go to FIN.
  - Multiply: shift-add on {acc,multiplier}.
  - Divide: restoring shift-subtract on {rem,quot}.
- FIN, on one edge:
  - Apply the sign correction:
    - product is negated if the operand signs differ;
    - quotient is negated if the signs differ;
    - remainder takes the dividend's sign.
  - Accumulate, modulo 2^(2*WIDTH): MADD → hilo + product; MSUB → hilo − product.
  - Register result_o; set ready_o=1 and busy_o=0; div_by_zero_o=0 (except the divide-by-zero case above); go to IDLE.
- Latency (E0 = edge sampling start_i):
  - ready_o is high for the single cycle after edge E(WIDTH+1). WIDTH=32 gives 33 cycles.
  - Divide-by-zero: ready_o is high after E1.
- ready_o is high for exactly one cycle.
- result_o and div_by_zero_o hold their values until the next FIN edge.
- Back-to-back: start_i may be asserted in the cycle ready_o is high; it is accepted, because the state is IDLE.
- start_i while busy_o=1 is ignored.
- Signed overflow case: DIV 0x80..0 / −1 gives quotient 0x80..0 (wraps), remainder 0.
- annul_i=1 sampled while busy_o=1 (CALC or FIN):
  - Next state IDLE, busy_o=0, no ready_o pulse.
  - result_o and div_by_zero_o are unchanged.
  - annul_i in IDLE has no effect except blocking start_i.
- Inputs are don't-care after E0; the engine uses only latched copies.

Test Plan:
1. WIDTH=32, MULT: opdata1=FFFFFFFD, opdata2=00000005 → ready_o after 33 cycles, result_o=FFFFFFFF_FFFFFFF1; busy_o high for exactly 33 cycles.
2. DIV: 0xFFFFFFF9 / 2 → result_o=FFFFFFFF_FFFFFFFD. DIVU: 7/2 → 00000001_00000003. DIV: 80000000 / FFFFFFFF → 00000000_80000000.
3. DIVU: 5/0 → ready_o after 1 cycle, result_o=0, div_by_zero_o=1. A following MULTU 2×3 → 00000000_00000006 and div_by_zero_o=0.
4. MSUBU: hilo=00000000_00000064, 3×4 → 00000000_00000058. MADD: hilo=FFFFFFFF_FFFFFFFF, 1×1 → 00000000_00000000. Back-to-back start in the ready_o cycle is accepted.
5. annul_i at cycle 10 of MULT → busy_o=0 next cycle, no ready_o, result_o keeps its prior value. Separately, rst low at cycle 20 → all outputs 0; the next start completes normally.
6. WIDTH=8, MULTU: FF×FF → result_o=FE01, ready_o after 9 cycles. DIV: 0x80/0x03 → result_o=FE_D6.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide engine shared by MULT, DIV, MADD and MSUB.
// One shift-add or restoring shift-subtract step per cycle on latched operand magnitudes.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_opCls;
    logic [2*WIDTH-1:0] r_hilo;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_dbz;
    logic               r_busy;
    logic               r_ready;
    logic [2*WIDTH-1:0] r_result;
    logic               r_dbzOut;

    logic               w_isDiv;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic               w_opDiv;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divTrial;
    logic               w_divOk;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodS;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_final;

    assign w_isDiv  = (op_i[2:1] == 2'b01);
    assign w_aNeg   = op_i[0] & opdata1_i[WIDTH-1];
    assign w_bNeg   = op_i[0] & opdata2_i[WIDTH-1];
    assign w_aMag   = w_aNeg ? -opdata1_i : opdata1_i;
    assign w_bMag   = w_bNeg ? -opdata2_i : opdata2_i;
    assign w_opDiv  = (r_opCls == 2'b01);

    // The partial remainder stays below the divisor, so the trial's top bit is a pure borrow flag.
    assign w_addend   = r_lo[0] ? r_b : '0;
    assign w_mulSum   = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_divShift = {r_hi, r_lo[WIDTH-1]};
    assign w_divTrial = w_divShift - {1'b0, r_b};
    assign w_divOk    = ~w_divTrial[WIDTH];

    assign w_prod  = {r_hi, r_lo};
    assign w_prodS = r_negRes ? -w_prod : w_prod;
    assign w_quot  = r_negRes ? -r_lo : r_lo;
    assign w_rem   = r_negRem ? -r_hi : r_hi;
    assign w_final = w_opDiv          ? {w_rem, w_quot} :
                     (r_opCls == 2'b10) ? r_hilo + w_prodS :
                     (r_opCls == 2'b11) ? r_hilo - w_prodS : w_prodS;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opCls  <= '0;
            r_hilo   <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
            r_dbzOut <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        r_opCls  <= op_i[2:1];
                        r_hilo   <= hilo_i;
                        r_negRes <= w_aNeg ^ w_bNeg;
                        r_negRem <= w_aNeg;
                        r_hi     <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        // Divide keeps the divisor in r_b; multiply keeps the multiplicand there.
                        r_b      <= w_isDiv ? w_bMag : w_aMag;
                        r_lo     <= w_isDiv ? w_aMag : w_bMag;
                        r_dbz    <= w_isDiv && (opdata2_i == '0);
                        r_state  <= (w_isDiv && (opdata2_i == '0)) ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    if (annul_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (w_opDiv) begin
                            r_hi <= w_divOk ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], w_divOk};
                        end else begin
                            r_hi <= w_mulSum[WIDTH:1];
                            r_lo <= {w_mulSum[0], r_lo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!annul_i) begin
                        r_result <= r_dbz ? '0 : w_final;
                        r_dbzOut <= r_dbz;
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign ready_o       = r_ready;
    assign result_o      = r_result;
    assign div_by_zero_o = r_dbzOut;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and random operations on a 32-bit and an 8-bit instance,
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, annul;
    logic [2:0]  op;
    logic [31:0] d1, d2;
    logic [63:0] hilo;
    logic        busy, ready, dbz;
    logic [63:0] res;

    logic        start8, annul8;
    logic [2:0]  op8;
    logic [7:0]  d1_8, d2_8;
    logic [15:0] hilo8;
    logic        busy8, ready8, dbz8;
    logic [15:0] res8;

    int checks = 0;
    int errors = 0;
    logic [63:0] lastExp = '0;
    logic        lastDbz = 1'b0;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
        .opdata1_i(d1), .opdata2_i(d2), .hilo_i(hilo),
        .busy_o(busy), .ready_o(ready), .result_o(res), .div_by_zero_o(dbz)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .op_i(op8),
        .opdata1_i(d1_8), .opdata2_i(d2_8), .hilo_i(hilo8),
        .busy_o(busy8), .ready_o(ready8), .result_o(res8), .div_by_zero_o(dbz8)
    );

    // Reference: extend operands to 64 bits, use native multiply/divide, keep the low 2w bits.
    function automatic logic [63:0] refModel(input int w, input logic [2:0] o,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] h);
        logic [63:0] wm, rm, ea, eb, p, q, r;
        longint sa, sb;
        wm = (64'd1 << w) - 64'd1;
        rm = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        sa = longint'(a << (64 - w)) >>> (64 - w);
        sb = longint'(b << (64 - w)) >>> (64 - w);
        ea = o[0] ? 64'(sa) : (a & wm);
        eb = o[0] ? 64'(sb) : (b & wm);
        if (o[2:1] == 2'b01) begin
            if ((b & wm) == 64'd0) return 64'd0;
            if (o[0]) begin
                q = 64'(sa / sb);
                r = 64'(sa % sb);
            end else begin
                q = ea / eb;
                r = ea % eb;
            end
            return (((r & wm) << w) | (q & wm)) & rm;
        end
        p = ea * eb;
        if (o[2:1] == 2'b10) p = h + p;
        if (o[2:1] == 2'b11) p = h - p;
        return p & rm;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge where ready_o was seen (or timeout).
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] h, input string tag);
        logic [63:0] exp;
        logic        expDbz;
        int          expLat, lat, busyCnt, busyAtReady;
        exp    = refModel(32, o, {32'd0, a}, {32'd0, b}, h);
        expDbz = (o[2:1] == 2'b01) && (b == 32'd0);
        expLat = expDbz ? 1 : 33;
        start = 1'b1; op = o; d1 = a; d2 = b; hilo = h;
        @(negedge clk);
        lat = 0; busyAtReady = 1;
        busyCnt = int'(busy);
        for (int n = 1; n <= 100; n++) begin
            start = 1'($urandom_range(0, 1));
            op = 3'($urandom); d1 = $urandom; d2 = $urandom; hilo = {$urandom, $urandom};
            @(negedge clk);
            if (ready) begin
                lat = n;
                busyAtReady = int'(busy);
                start = 1'b0;
                break;
            end
            busyCnt += int'(busy);
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " result"}, res, exp);
        checkOutput({tag, " div_by_zero"}, 64'(dbz), 64'(expDbz));
        checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(expLat));
        checkOutput({tag, " busy at ready"}, 64'(busyAtReady), 64'd0);
        lastExp = exp;
        lastDbz = expDbz;
    endtask

    task automatic idleGap(input string tag);
        @(negedge clk);
        checkOutput({tag, " ready single cycle"}, 64'(ready), 64'd0);
        checkOutput({tag, " result held"}, res, lastExp);
        checkOutput({tag, " dbz held"}, 64'(dbz), 64'(lastDbz));
    endtask

    task automatic applyStimulus8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input logic [15:0] h, input string tag);
        logic [63:0] exp;
        logic        expDbz;
        int          expLat, lat;
        exp    = refModel(8, o, {56'd0, a}, {56'd0, b}, {48'd0, h});
        expDbz = (o[2:1] == 2'b01) && (b == 8'd0);
        expLat = expDbz ? 1 : 9;
        start8 = 1'b1; op8 = o; d1_8 = a; d2_8 = b; hilo8 = h;
        @(negedge clk);
        start8 = 1'b0; d1_8 = 8'($urandom); d2_8 = 8'($urandom);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready8) begin
                lat = n;
                break;
            end
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " result"}, {48'd0, res8}, exp);
        checkOutput({tag, " div_by_zero"}, 64'(dbz8), 64'(expDbz));
        @(negedge clk);
        checkOutput({tag, " ready single cycle"}, 64'(ready8), 64'd0);
    endtask

    initial begin
        int readyCnt;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;

        rst = 1'b0; start = 1'b0; annul = 1'b0; op = '0; d1 = '0; d2 = '0; hilo = '0;
        start8 = 1'b0; annul8 = 1'b0; op8 = '0; d1_8 = '0; d2_8 = '0; hilo8 = '0;
        #22;
        checkOutput("reset outputs32", {res[60:0], busy, ready, dbz}, 64'd0);
        checkOutput("reset outputs8", {45'd0, res8, busy8, ready8, dbz8}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(3'b001, 32'hFFFFFFFD, 32'h00000005, '0, "MULT -3x5");
        idleGap("MULT");
        applyStimulus(3'b011, 32'hFFFFFFF9, 32'h00000002, '0, "DIV -7/2");
        idleGap("DIV");
        applyStimulus(3'b010, 32'h00000007, 32'h00000002, '0, "DIVU 7/2");
        idleGap("DIVU");
        applyStimulus(3'b011, 32'h80000000, 32'hFFFFFFFF, '0, "DIV overflow");
        idleGap("DIV overflow");

        // Abort a multiply at cycle 10; the previous result must survive.
        start = 1'b1; op = 3'b000; d1 = 32'h1234; d2 = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        checkOutput("annul busy drop", 64'(busy), 64'd0);
        readyCnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            readyCnt += int'(ready);
        end
        checkOutput("annul no ready", 64'(readyCnt), 64'd0);
        checkOutput("annul result held", res, lastExp);

        start = 1'b1; annul = 1'b1; op = 3'b000;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        checkOutput("start blocked by annul", 64'(busy), 64'd0);

        applyStimulus(3'b010, 32'h00000005, 32'h00000000, '0, "DIVU by zero");
        idleGap("DIVU by zero");
        applyStimulus(3'b000, 32'h00000002, 32'h00000003, '0, "MULTU 2x3");
        idleGap("MULTU");

        applyStimulus(3'b110, 32'h00000003, 32'h00000004, 64'h64, "MSUBU");
        applyStimulus(3'b101, 32'h00000001, 32'h00000001, '1, "MADD back-to-back");
        idleGap("MADD");

        applyStimulus(3'b011, 32'h00000009, 32'h00000000, '0, "DIV by zero");
        start = 1'b1; op = 3'b001; d1 = 32'hFFFF0000; d2 = 32'h00000777;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid-op reset", {res[60:0], busy, ready, dbz}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        lastExp = '0; lastDbz = 1'b0;
        idleGap("after reset");
        applyStimulus(3'b100, 32'hDEADBEEF, 32'h00001234, 64'hFFFFFFFF_00000000, "MADDU after reset");

        for (int i = 0; i < 20; i++) begin
            ro = 3'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            applyStimulus(ro, ra, rb, {$urandom, $urandom}, $sformatf("rand32 #%0d", i));
            if ($urandom_range(0, 1) == 1) idleGap($sformatf("rand32 gap #%0d", i));
        end

        applyStimulus8(3'b000, 8'hFF, 8'hFF, '0, "W8 MULTU FFxFF");
        applyStimulus8(3'b011, 8'h80, 8'h03, '0, "W8 DIV 80/03");
        for (int i = 0; i < 12; i++) begin
            ra8 = 8'($urandom);
            rb8 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus8(3'($urandom), ra8, rb8, 16'($urandom), $sformatf("rand8 #%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
